cpu: RTL and testbench

Single-cycle 32-bit MIPS-subset processor with internal instruction ROM, 32×32 register file and 64-word data RAM. It executes one instruction per rising clock edge and exposes the current ALU result on `tmp` for observation. It is the top of the processor datapath; nothing else is required to run the built-in program.

---
 rtl/cpu.sv | 155 +++++++++++++++
 tb/tb_cpu.sv | 126 ++++++++++++
 2 files changed

// File: rtl/cpu.sv
// cpu: single-cycle MIPS-subset processor with a hard-wired program ROM,
// a 32x32 register file and a 64-word data RAM, all in one clock domain.
module cpu (
    input  logic        Clock,
    input  logic        Reset,
    output logic [31:0] tmp
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Built-in program; every unlisted word is 0, which decodes as a NOP.
    function automatic logic [31:0] rom_word(input logic [5:0] idx);
        logic [31:0] w;
        case (idx)
            6'd0:    w = 32'h2001_0005; // addi $1,$0,5
            6'd1:    w = 32'h2002_0003; // addi $2,$0,3
            6'd2:    w = 32'h0022_1820; // add  $3,$1,$2
            6'd3:    w = 32'h0022_2022; // sub  $4,$1,$2
            6'd4:    w = 32'h0022_2824; // and  $5,$1,$2
            6'd5:    w = 32'h0022_3025; // or   $6,$1,$2
            6'd6:    w = 32'h0041_382A; // slt  $7,$2,$1
            6'd7:    w = 32'hAC03_0004; // sw   $3,4($0)
            6'd8:    w = 32'h8C08_0004; // lw   $8,4($0)
            6'd9:    w = 32'h1103_0001; // beq  $8,$3,+1
            6'd10:   w = 32'h2009_0063; // addi $9,$0,99
            6'd11:   w = 32'h0800_0000; // j    0
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q   [32];
    logic [31:0] rf_d   [32];
    logic [31:0] dmem_q [64];
    logic [31:0] dmem_d [64];

    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_ext, rs_val, rt_val, pc_plus4;

    logic [31:0] alu_res;
    logic        reg_we, mem_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;

    assign instr    = rom_word(pc_q[7:2]);
    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm_ext  = {{16{instr[15]}}, instr[15:0]};
    assign rs_val   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
    assign pc_plus4 = pc_q + 32'd4;

    // Decode and execute: ALU result, write-back controls and next PC.
    always_comb begin
        alu_res = 32'd0;
        reg_we  = 1'b0;
        reg_wa  = 5'd0;
        reg_wd  = 32'd0;
        mem_we  = 1'b0;
        pc_d    = pc_plus4;
        case (opcode)
            OP_RTYPE: begin
                // A nonzero shift amount is not a valid encoding for these ops.
                if (shamt == 5'd0) begin
                    case (funct)
                        FN_ADD: begin alu_res = rs_val + rt_val; reg_we = 1'b1; end
                        FN_SUB: begin alu_res = rs_val - rt_val; reg_we = 1'b1; end
                        FN_AND: begin alu_res = rs_val & rt_val; reg_we = 1'b1; end
                        FN_OR:  begin alu_res = rs_val | rt_val; reg_we = 1'b1; end
                        FN_SLT: begin
                            alu_res = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
                            reg_we  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                reg_wa = rd;
                reg_wd = alu_res;
            end
            OP_ADDI: begin
                alu_res = rs_val + imm_ext;
                reg_we  = 1'b1;
                reg_wa  = rt;
                reg_wd  = alu_res;
            end
            OP_LW: begin
                // Reads the RAM as it stood before this edge.
                alu_res = rs_val + imm_ext;
                reg_we  = 1'b1;
                reg_wa  = rt;
                reg_wd  = dmem_q[alu_res[7:2]];
            end
            OP_SW: begin
                alu_res = rs_val + imm_ext;
                mem_we  = 1'b1;
            end
            OP_BEQ: begin
                alu_res = rs_val - rt_val;
                if (rs_val == rt_val) begin
                    pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
                end
            end
            OP_J: begin
                pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
            end
            default: ;
        endcase
    end

    // Next-state register file and data RAM; $0 writes are dropped here.
    always_comb begin
        rf_d   = rf_q;
        dmem_d = dmem_q;
        if (reg_we && (reg_wa != 5'd0)) begin
            rf_d[reg_wa] = reg_wd;
        end
        if (mem_we) begin
            dmem_d[alu_res[7:2]] = rt_val;
        end
    end

    // State commit; reset clears PC, registers and data RAM.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            pc_q <= 32'd0;
            for (int i = 0; i < 32; i++) rf_q[i]   <= 32'd0;
            for (int i = 0; i < 64; i++) dmem_q[i] <= 32'd0;
        end else begin
            pc_q   <= pc_d;
            rf_q   <= rf_d;
            dmem_q <= dmem_d;
        end
    end

    assign tmp = Reset ? alu_res : 32'd0;

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed checks of the built-in program, reset behaviour and $0 protection.
module tb_cpu;

    logic        Clock;
    logic        Reset;
    logic [31:0] tmp;

    int checks;
    int errors;

    logic [31:0] exp_tmp [9];
    logic [31:0] exp_reg [8];

    cpu dut (
        .Clock (Clock),
        .Reset (Reset),
        .tmp   (tmp)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // tmp expected for ROM words 0..8
        exp_tmp[0] = 32'd5; exp_tmp[1] = 32'd3; exp_tmp[2] = 32'd8;
        exp_tmp[3] = 32'd2; exp_tmp[4] = 32'd1; exp_tmp[5] = 32'd7;
        exp_tmp[6] = 32'd1; exp_tmp[7] = 32'd4; exp_tmp[8] = 32'd4;
        // $1..$7 after the arithmetic block
        exp_reg[0] = 32'd0; exp_reg[1] = 32'd5; exp_reg[2] = 32'd3;
        exp_reg[3] = 32'd8; exp_reg[4] = 32'd2; exp_reg[5] = 32'd1;
        exp_reg[6] = 32'd7; exp_reg[7] = 32'd1;

        // Reset held for two edges
        Reset = 1'b0;
        step();
        step();
        check("reset_pc", dut.pc_q, 32'd0);
        for (int r = 0; r < 10; r++) check($sformatf("reset_r%0d", r), dut.rf_q[r], 32'd0);
        check("reset_tmp", tmp, 32'd0);
        Reset = 1'b1;
        #1;
        check("release_tmp", tmp, 32'd5);
        $display("reset released: tmp=%0d pc=%0d", tmp, dut.pc_q);

        // Arithmetic sequence, words 0..6
        for (int k = 0; k < 7; k++) begin
            check($sformatf("arith_tmp_w%0d", k), tmp, exp_tmp[k]);
            $display("word %0d: tmp=%0d", k, tmp);
            step();
        end
        for (int r = 1; r < 8; r++) check($sformatf("arith_r%0d", r), dut.rf_q[r], exp_reg[r]);

        // Memory round trip, words 7 and 8
        check("sw_tmp", tmp, exp_tmp[7]);
        step();
        check("sw_dmem1", dut.dmem_q[1], 32'd8);
        check("lw_tmp", tmp, exp_tmp[8]);
        step();
        check("lw_r8", dut.rf_q[8], 32'd8);
        $display("lw: r8=%0d dmem1=%0d", dut.rf_q[8], dut.dmem_q[1]);

        // Branch and jump
        check("beq_pc", dut.pc_q, 32'd36);
        check("beq_tmp", tmp, 32'd0);
        step();
        check("beq_target", dut.pc_q, 32'd44);
        check("skip_r9", dut.rf_q[9], 32'd0);
        check("j_tmp", tmp, 32'd0);
        step();
        check("j_pc", dut.pc_q, 32'd0);
        check("wrap_tmp", tmp, 32'd5);
        $display("jump: pc=%0d tmp=%0d", dut.pc_q, tmp);

        // Mid-program reset after 5 more instructions
        for (int k = 0; k < 5; k++) begin
            check($sformatf("pre_rst_tmp_w%0d", k), tmp, exp_tmp[k]);
            step();
        end
        check("pre_rst_pc", dut.pc_q, 32'd20);
        Reset = 1'b0;
        #1;
        check("midrst_tmp_low", tmp, 32'd0);
        step();
        check("midrst_pc", dut.pc_q, 32'd0);
        for (int r = 1; r < 8; r++) check($sformatf("midrst_r%0d", r), dut.rf_q[r], 32'd0);
        check("midrst_dmem1", dut.dmem_q[1], 32'd0);
        Reset = 1'b1;
        #1;
        for (int k = 0; k < 7; k++) begin
            check($sformatf("rerun_tmp_w%0d", k), tmp, exp_tmp[k]);
            $display("rerun word %0d: tmp=%0d", k, tmp);
            step();
        end
        for (int r = 1; r < 8; r++) check($sformatf("rerun_r%0d", r), dut.rf_q[r], exp_reg[r]);

        // $0 protection: substitute add $0,$1,$2 at PC=28
        check("zero_pc_before", dut.pc_q, 32'd28);
        force dut.instr = 32'h0022_0020;
        #1;
        check("zero_tmp", tmp, 32'd8);
        step();
        check("zero_r0", dut.rf_q[0], 32'd0);
        check("zero_pc_after", dut.pc_q, 32'd32);
        release dut.instr;
        $display("add $0: r0=%0d pc=%0d", dut.rf_q[0], dut.pc_q);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
